multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- opcode_i  in  6  IR[31:26]; sampled in DECODE.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_write_o  out  1  unconditional PC load.
- branch_eq_o  out  1  PC load if ALU zero.
- branch_ne_o  out  1  PC load if not zero.
- i_or_d_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read.
- mem_write_o  out  1  memory write.
- ir_write_o  out  1  IR load.
- mem_to_reg_o  out  1  writeback source: 1 = MDR.
- reg_dst_o  out  1  destination: 1 = rd, 0 = rt.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  1  operand A: 0 = PC, 1 = A.
- alu_src_b_o  out  2  operand B: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- pc_src_o  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_op_o  out  3  ALU operation: 111 R-type funct, 100 add, 001 lui, 010 or, 011 and, 101 mem add, 110 sub.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state code, for debug.

Function
REQ-003 State codes SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11.
REQ-004 Outputs SHALL be Moore (a function of state only), except ir_write_o and pc_write_o in FETCH, which SHALL equal mem_ready_i; every output not listed for a state SHALL be 0.
REQ-005 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_src=00; it SHALL hold while mem_ready_i=0, then go to DECODE.
REQ-006 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=100; the next state SHALL follow opcode_i:
- 0x00 -> EXEC_R.
- 0x08, 0x0f, 0x0d, 0x0c -> EXEC_I.
- 0x23, 0x2b -> MEM_ADDR.
- 0x02 -> JUMP.
- 0x04, 0x05 -> BRANCH.
- any other opcode -> FETCH, with illegal_o=1 for that one cycle.
REQ-007 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=111, then go to R_WB; R_WB SHALL drive reg_dst=1, reg_write=1, then go to FETCH.
REQ-008 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, with alu_op of 100/001/010/011 for addi/lui/ori/andi; the opcode SHALL be latched in DECODE. I_WB SHALL drive reg_dst=0, reg_write=1, then go to FETCH.
REQ-009 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=101, then go to MEM_RD for lw or MEM_WR for sw.
REQ-010 MEM_RD SHALL drive mem_read=1, i_or_d=1 and hold until mem_ready_i=1, then go to MEM_WB; MEM_WB SHALL drive mem_to_reg=1, reg_dst=0, reg_write=1, then go to FETCH.
REQ-011 MEM_WR SHALL drive mem_write=1, i_or_d=1 and hold until mem_ready_i=1, then go to FETCH.
REQ-012 JUMP SHALL drive pc_write=1, pc_src=10, then go to FETCH.
REQ-013 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, branch_eq=1 for beq or branch_ne=1 for bne, then go to FETCH.
REQ-014 With zero wait states, cycles per instruction SHALL be: R-type 4, I-type 4, lw 5, sw 4, branch 3, jump 3; each memory wait cycle SHALL add exactly one cycle.
REQ-015 While a memory state is held, all of its outputs SHALL stay stable, and mem_write_o SHALL never be asserted in more than one consecutive access sequence.
REQ-016 Undefined state codes SHALL transition to FETCH on the next edge.

Reset
REQ-017 With rst_i=1 at a rising edge, the state SHALL become FETCH regardless of the current state, including mid-wait in MEM_RD or MEM_WR.
REQ-018 While rst_i=1, all outputs SHALL be forced to 0, and state_o SHALL read 0 after the edge.

Configuration
REQ-019 With the macro MULTICYCLE_CONTROL_BRANCH_EN defined, opcodes 0x04 and 0x05 SHALL go to BRANCH; without it, the BRANCH state SHALL not exist and those opcodes SHALL take the illegal path (FETCH plus an illegal_o pulse).

Structure
REQ-020 The state encoding, opcode constants and alu_op codes SHALL live in the shared package mips_pkg.
REQ-021 Opcode classification SHALL be a combinational sub-module named opcode_class, with outputs is_r, is_imm, is_mem, is_jmp, is_br and is_illegal.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
- Reset, then mem_ready_i=1 and opcode 0x00: states 0,1,6,7,0; reg_write_o=1 only in R_WB; exactly 4 cycles.
- lw (0x23) with mem_ready_i=0 for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0; mem_read_o held at 1 for 3 cycles; mem_to_reg_o=1 in MEM_WB.
- Opcode 0x3f: DECODE returns to FETCH with illegal_o high for exactly 1 cycle; reg_write_o and mem_write_o stay 0.
- beq (0x04) with the macro defined: state 10, branch_eq_o=1, alu_op_o=110, 3 cycles; without the macro: illegal_o pulses.
- sw (0x2b) with rst_i asserted during a MEM_WR wait: the next state is FETCH, mem_write_o drops to 0, and no further write occurs.
- ori (0x0d) then j (0x02) back-to-back: alu_op_o=010 in EXEC_I, pc_src_o=10 with pc_write_o=1 in JUMP, 7 cycles total.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control slice.
// MULTICYCLE_CONTROL_BRANCH_EN adds the BRANCH state for beq/bne.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
    S_BRANCH   = 4'd10,
`endif
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [2:0] ALU_LUI   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_MEM   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // Moore control word; FETCH's ir/pc load is added by the top.
  function automatic ctrl_t ctrl_of(
    state_t     s,
    logic [5:0] op
  );
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_MEM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_LUI:  c.alu_op = ALU_LUI;
          OP_ORI:  c.alu_op = ALU_OR;
          OP_ANDI: c.alu_op = ALU_AND;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
        c.branch_eq = (op == OP_BEQ);
        c.branch_ne = (op == OP_BNE);
      end
`endif
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier for the multicycle control.
// Branches count as illegal unless MULTICYCLE_CONTROL_BRANCH_EN.
module opcode_class
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_r,
  output logic       is_imm,
  output logic       is_mem,
  output logic       is_jmp,
  output logic       is_br,
  output logic       is_illegal
);

  always_comb begin
    is_r   = (opcode == OP_R);
    is_imm = opcode inside {OP_ADDI, OP_LUI,
                            OP_ORI, OP_ANDI};
    is_mem = opcode inside {OP_LW, OP_SW};
    is_jmp = (opcode == OP_J);
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
    is_br  = opcode inside {OP_BEQ, OP_BNE};
`else
    is_br  = 1'b0;
`endif
    is_illegal = !(is_r | is_imm | is_mem |
                   is_jmp | is_br);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with registered control word.
// Define MULTICYCLE_CONTROL_BRANCH_EN to enable beq/bne.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic [5:0] op_d;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl;
  logic       illegal_q;
  logic       bad_op;
  logic       fetch_ld;

  logic is_r;
  logic is_imm;
  logic is_mem;
  logic is_jmp;
  logic is_br;
  logic is_illegal;

  opcode_class u_class (
    .opcode     (opcode_i),
    .is_r       (is_r),
    .is_imm     (is_imm),
    .is_mem     (is_mem),
    .is_jmp     (is_jmp),
    .is_br      (is_br),
    .is_illegal (is_illegal)
  );

`ifdef MULTICYCLE_CONTROL_BRANCH_EN
  assign bad_op = is_illegal;
`else
  assign bad_op = is_illegal | is_br;
`endif

  assign op_d = (state_q == S_DECODE)
              ? opcode_i : op_q;

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:
        state_d = mem_ready_i ? S_DECODE
                              : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_EXEC_R;
          is_imm:  state_d = S_EXEC_I;
          is_mem:  state_d = S_MEM_ADDR;
          is_jmp:  state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
          is_br:   state_d = S_BRANCH;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (op_q == OP_LW) ? S_MEM_RD
                                  : S_MEM_WR;
      S_MEM_RD:
        state_d = mem_ready_i ? S_MEM_WB
                              : S_MEM_RD;
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR:
        state_d = mem_ready_i ? S_FETCH
                              : S_MEM_WR;
      S_EXEC_R: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
      S_BRANCH: state_d = S_FETCH;
`endif
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control word is precomputed for the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      ctrl_q    <= ctrl_of(S_FETCH, '0);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ctrl_q    <= ctrl_of(state_d, op_d);
      illegal_q <= (state_q == S_DECODE)
                 && bad_op;
    end
  end

  assign ctrl     = rst_i ? '0 : ctrl_q;
  assign fetch_ld = !rst_i && mem_ready_i
                 && (state_q == S_FETCH);

  assign pc_write_o   = ctrl.pc_write | fetch_ld;
  assign ir_write_o   = ctrl.ir_write | fetch_ld;
  assign branch_eq_o  = ctrl.branch_eq;
  assign branch_ne_o  = ctrl.branch_ne;
  assign i_or_d_o     = ctrl.i_or_d;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign reg_dst_o    = ctrl.reg_dst;
  assign reg_write_o  = ctrl.reg_write;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign pc_src_o     = ctrl.pc_src;
  assign alu_op_o     = ctrl.alu_op;
  assign illegal_o    = illegal_q & ~rst_i;
  assign state_o      = rst_i ? 4'd0 : state_q;

endmodule
